// File: rtl/geogenius_pkg.sv
// Shared constants for the geogenius round sequencer: state codes and counter widths.
package geogenius_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned TMR_W  = 16;

  typedef enum logic [3:0] {
    StInicial    = 4'h0,
    StPrepara    = 4'h1,
    StMostra     = 4'h2,
    StApaga      = 4'h3,
    StEspera     = 4'h4,
    StRegistra   = 4'h5,
    StCompara    = 4'h6,
    StProxJogada = 4'h7,
    StProxRodada = 4'h8,
    StAcertou    = 4'hA,
    StTout       = 4'hD,
    StErrou      = 4'hE
  } estado_t;

endpackage

// File: rtl/contador_temporizador.sv
// Up-counter with synchronous clear; fim flags the last counted cycle of a window of
// limite cycles (a limit of 0 behaves like 1).
module contador_temporizador
  import geogenius_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] valor_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q <= '0;
    end else if (zera) begin
      valor_q <= '0;
    end else if (conta) begin
      valor_q <= valor_q + W'(1);
    end
  end

  assign fim = conta && (({1'b0, valor_q} + (W + 1)'(1)) >= {1'b0, limite});

endmodule

// File: rtl/controle_rodadas.sv
// Round sequencer for the geogenius memory game.
// Define TIMEOUT_EN to build the per-move timeout timer and the TOUT terminal state.
module controle_rodadas
  import geogenius_pkg::*;
#(
  parameter int unsigned N_RODADAS = 16,
  parameter int unsigned T_LED     = 1000,
  parameter int unsigned T_APAGA   = 250,
  parameter int unsigned T_TIMEOUT = 5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              jogar,
  input  logic              dificuldade,
  input  logic              fez_jogada,
  input  logic              jogada_igual_memoria,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic              liga_led,
  output logic              registraR,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic [3:0]        db_estado
);

  localparam logic [ADDR_W-1:0] UltimaRodada = ADDR_W'(N_RODADAS - 1);
  localparam logic [TMR_W-1:0]  TLedN        = TMR_W'(T_LED);
  localparam logic [TMR_W-1:0]  TLedH        = TMR_W'(T_LED >> 1);
  localparam logic [TMR_W-1:0]  TApaga       = TMR_W'(T_APAGA);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] rodada_q, rodada_d;
  logic              dificil_q, dificil_d;
  logic              fim_led, fim_tout;
  logic              led_ativo;
  logic [TMR_W-1:0]  led_limite;

  // One timer serves both the lit window and the gap; it restarts at each phase boundary.
  assign led_ativo  = (estado_q == StMostra) || (estado_q == StApaga);
  assign led_limite = (estado_q == StMostra) ? (dificil_q ? TLedH : TLedN) : TApaga;

  contador_temporizador #(.W(TMR_W)) u_tmr_led (
    .clock  (clock),
    .reset  (reset),
    .zera   (!led_ativo || fim_led),
    .conta  (led_ativo),
    .limite (led_limite),
    .fim    (fim_led)
  );

`ifdef TIMEOUT_EN
  localparam logic [TMR_W-1:0] TToutN = TMR_W'(T_TIMEOUT);
  localparam logic [TMR_W-1:0] TToutH = TMR_W'(T_TIMEOUT >> 1);

  contador_temporizador #(.W(TMR_W)) u_tmr_jogada (
    .clock  (clock),
    .reset  (reset),
    .zera   (estado_q != StEspera),
    .conta  (estado_q == StEspera),
    .limite (dificil_q ? TToutH : TToutN),
    .fim    (fim_tout)
  );

  assign timeout = (estado_q == StTout);
`else
  logic unused_t_timeout;
  assign unused_t_timeout = ^TMR_W'(T_TIMEOUT);
  assign fim_tout         = 1'b0;
  assign timeout          = 1'b0;
`endif

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    rodada_d   = rodada_q;
    dificil_d  = dificil_q;
    unique case (estado_q)
      StInicial, StAcertou, StErrou, StTout: begin
        if (jogar) begin
          estado_d   = StPrepara;
          endereco_d = '0;
          rodada_d   = '0;
        end
      end
      StPrepara: begin
        endereco_d = '0;
        rodada_d   = '0;
        dificil_d  = dificuldade;
        estado_d   = StMostra;
      end
      StMostra: begin
        if (fim_led) estado_d = StApaga;
      end
      StApaga: begin
        if (fim_led) begin
          if (endereco_q == rodada_q) begin
            endereco_d = '0;
            estado_d   = StEspera;
          end else begin
            endereco_d = endereco_q + ADDR_W'(1);
            estado_d   = StMostra;
          end
        end
      end
      StEspera: begin
        // A move arriving on the terminal-count cycle takes priority over the timeout.
        if (fez_jogada)    estado_d = StRegistra;
        else if (fim_tout) estado_d = StTout;
      end
      StRegistra: estado_d = StCompara;
      StCompara: begin
        if (!jogada_igual_memoria)          estado_d = StErrou;
        else if (endereco_q < rodada_q)     estado_d = StProxJogada;
        else if (rodada_q == UltimaRodada)  estado_d = StAcertou;
        else                                estado_d = StProxRodada;
      end
      StProxJogada: begin
        endereco_d = endereco_q + ADDR_W'(1);
        estado_d   = StEspera;
      end
      StProxRodada: begin
        rodada_d   = rodada_q + ADDR_W'(1);
        endereco_d = '0;
        estado_d   = StMostra;
      end
      default: estado_d = StInicial;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= StInicial;
      endereco_q <= '0;
      rodada_q   <= '0;
      dificil_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      rodada_q   <= rodada_d;
      dificil_q  <= dificil_d;
    end
  end

  assign endereco  = endereco_q;
  assign rodada    = rodada_q;
  assign liga_led  = (estado_q == StMostra);
  assign registraR = (estado_q == StRegistra);
  assign acertou   = (estado_q == StAcertou);
  assign errou     = (estado_q == StErrou);
  assign pronto    = acertou || errou || (estado_q == StTout);
  assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_rodadas.sv
// Directed bench for controle_rodadas with N_RODADAS=4, T_LED=4, T_APAGA=2, T_TIMEOUT=8.
module tb_controle_rodadas;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       jogar = 1'b0;
  logic       dificuldade = 1'b0;
  logic       fez_jogada = 1'b0;
  logic       igual = 1'b0;
  logic [3:0] endereco, rodada, db_estado;
  logic       liga_led, registraR, pronto, acertou, errou, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  controle_rodadas #(
    .N_RODADAS (4),
    .T_LED     (4),
    .T_APAGA   (2),
    .T_TIMEOUT (8)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .jogar                (jogar),
    .dificuldade          (dificuldade),
    .fez_jogada           (fez_jogada),
    .jogada_igual_memoria (igual),
    .endereco             (endereco),
    .rodada               (rodada),
    .liga_led             (liga_led),
    .registraR            (registraR),
    .pronto               (pronto),
    .acertou              (acertou),
    .errou                (errou),
    .timeout              (timeout),
    .db_estado            (db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got no summary expected summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    jogar = 0; fez_jogada = 0; igual = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // jogar pulse; returns in the first MOSTRA cycle.
  task automatic start_game();
    jogar = 1;
    tick();
    jogar = 0;
    tick();
  endtask

  // Counts MOSTRA entries until ESPERA is observed (bounded).
  task automatic run_to_espera(output int lit, output bit ok);
    logic [3:0] prev;
    lit = 0; ok = 0; prev = 4'h0;
    for (int i = 0; i < 200; i++) begin
      if (db_estado == 4'h4) begin
        ok = 1;
        break;
      end
      if (db_estado == 4'h2 && prev != 4'h2) lit++;
      prev = db_estado;
      tick();
    end
  endtask

  // One-cycle move pulse; returns on the cycle after COMPARA.
  task automatic move(input bit ok_move, output bit reg_seen);
    fez_jogada = 1; igual = ok_move;
    tick();
    fez_jogada = 0;
    reg_seen = registraR;
    tick();
    tick();
  endtask

  task automatic test_reset();
    int lit; bit ok; bit rs;
    reset = 1;
    tick();
    n_tests++; if (db_estado !== 4'h0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", db_estado); end
    n_tests++; if ({liga_led, registraR, pronto, acertou, errou, timeout} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000", {liga_led, registraR, pronto, acertou, errou, timeout}); end
    reset = 0;
    start_game();
    run_to_espera(lit, ok);
    move(1, rs);
    tick();
    n_tests++; if (db_estado !== 4'h2 || rodada !== 4'd1) begin
      n_fail++; $display("FAIL reset_setup: got state %h rodada %0d expected 2 / 1", db_estado, rodada); end
    tick();
    #2 reset = 1;
    #1;
    n_tests++; if (db_estado !== 4'h0 || liga_led !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_state: got %h led %b expected 0 led 0", db_estado, liga_led); end
    n_tests++; if (endereco !== 4'd0 || rodada !== 4'd0) begin
      n_fail++; $display("FAIL reset_async_cnt: got end %0d rod %0d expected 0 0", endereco, rodada); end
    tick();
    reset = 0;
  endtask

  task automatic test_full_game();
    int lit; bit ok; bit rs; logic [3:0] exp_st;
    do_reset();
    dificuldade = 0;
    start_game();
    n_tests++; if (db_estado !== 4'h2 || liga_led !== 1'b1) begin
      n_fail++; $display("FAIL game_first_mostra: got %h led %b expected 2 led 1", db_estado, liga_led); end
    for (int r = 0; r < 4; r++) begin
      run_to_espera(lit, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL game_reach_espera r%0d: got %h expected 4", r, db_estado); end
      n_tests++; if (lit != r + 1) begin n_fail++; $display("FAIL game_lit r%0d: got %0d expected %0d", r, lit, r + 1); end
      n_tests++; if (rodada !== 4'(r)) begin n_fail++; $display("FAIL game_rodada: got %0d expected %0d", rodada, r); end
      for (int m = 0; m <= r; m++) begin
        n_tests++; if (endereco !== 4'(m)) begin
          n_fail++; $display("FAIL game_endereco r%0d: got %0d expected %0d", r, endereco, m); end
        move(1, rs);
        n_tests++; if (rs !== 1'b1) begin n_fail++; $display("FAIL game_registraR: got %b expected 1", rs); end
        exp_st = (m < r) ? 4'h7 : ((r == 3) ? 4'hA : 4'h8);
        n_tests++; if (db_estado !== exp_st) begin
          n_fail++; $display("FAIL game_after_compara r%0d m%0d: got %h expected %h", r, m, db_estado, exp_st); end
        if (exp_st != 4'hA) tick();
      end
    end
    n_tests++; if ({pronto, acertou, errou, timeout} !== 4'b1100 || rodada !== 4'd3) begin
      n_fail++; $display("FAIL game_win: got flags %b rodada %0d expected 1100 / 3", {pronto, acertou, errou, timeout}, rodada); end
    repeat (3) tick();
    n_tests++; if (db_estado !== 4'hA || acertou !== 1'b1) begin
      n_fail++; $display("FAIL game_win_hold: got %h acertou %b expected A 1", db_estado, acertou); end
  endtask

  task automatic test_error();
    int lit; bit ok; bit rs;
    do_reset();
    start_game();
    run_to_espera(lit, ok);
    move(1, rs);
    tick();
    run_to_espera(lit, ok);
    move(1, rs);
    n_tests++; if (db_estado !== 4'h7) begin n_fail++; $display("FAIL err_prox_jogada: got %h expected 7", db_estado); end
    tick();
    move(0, rs);
    n_tests++; if (db_estado !== 4'hE || {pronto, acertou, errou} !== 3'b101 || rodada !== 4'd1) begin
      n_fail++; $display("FAIL err_state: got %h flags %b rodada %0d expected E 101 1", db_estado, {pronto, acertou, errou}, rodada); end
    jogar = 1;
    tick();
    jogar = 0;
    n_tests++; if (db_estado !== 4'h1 || rodada !== 4'd0 || errou !== 1'b0) begin
      n_fail++; $display("FAIL err_restart: got %h rodada %0d errou %b expected 1 0 0", db_estado, rodada, errou); end
  endtask

  task automatic test_timing();
    int n;
    do_reset();
    dificuldade = 0;
    start_game();
    n = 0;
    while (db_estado == 4'h2 && n < 20) begin n++; tick(); end
    n_tests++; if (n != 4) begin n_fail++; $display("FAIL mostra_len_normal: got %0d expected 4", n); end
    n = 0;
    while (db_estado == 4'h3 && n < 20) begin n++; tick(); end
    n_tests++; if (n != 2 || db_estado !== 4'h4) begin
      n_fail++; $display("FAIL apaga_len: got %0d next %h expected 2 next 4", n, db_estado); end
    do_reset();
    dificuldade = 1;
    jogar = 1;
    tick();
    jogar = 0;
    tick();
    dificuldade = 0;
    n = 0;
    while (db_estado == 4'h2 && n < 20) begin n++; tick(); end
    n_tests++; if (n != 2) begin n_fail++; $display("FAIL mostra_len_hard: got %0d expected 2", n); end
  endtask

  task automatic test_ignore_mostra();
    int lit; bit ok;
    do_reset();
    start_game();
    fez_jogada = 1; igual = 1;
    tick();
    fez_jogada = 0;
    jogar = 1;
    tick();
    jogar = 0;
    n_tests++; if (db_estado !== 4'h2) begin n_fail++; $display("FAIL ignore_in_mostra: got %h expected 2", db_estado); end
    run_to_espera(lit, ok);
    n_tests++; if (!ok || endereco !== 4'd0 || lit != 1) begin
      n_fail++; $display("FAIL ignore_then_espera: got ok %b end %0d lit %0d expected 1 0 1", ok, endereco, lit); end
  endtask

`ifdef TIMEOUT_EN
  task automatic test_timeout();
    int lit; bit ok;
    do_reset();
    dificuldade = 0;
    start_game();
    run_to_espera(lit, ok);
    repeat (7) tick();
    n_tests++; if (db_estado !== 4'h4 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL tout_before: got %h timeout %b expected 4 0", db_estado, timeout); end
    tick();
    n_tests++; if (db_estado !== 4'hD || timeout !== 1'b1 || pronto !== 1'b1) begin
      n_fail++; $display("FAIL tout_normal: got %h timeout %b pronto %b expected D 1 1", db_estado, timeout, pronto); end
    do_reset();
    dificuldade = 1;
    start_game();
    dificuldade = 0;
    run_to_espera(lit, ok);
    repeat (3) tick();
    n_tests++; if (db_estado !== 4'h4) begin n_fail++; $display("FAIL tout_hard_before: got %h expected 4", db_estado); end
    tick();
    n_tests++; if (db_estado !== 4'hD || timeout !== 1'b1) begin
      n_fail++; $display("FAIL tout_hard: got %h timeout %b expected D 1", db_estado, timeout); end
  endtask

  task automatic test_tie();
    int lit; bit ok;
    do_reset();
    start_game();
    run_to_espera(lit, ok);
    repeat (7) tick();
    fez_jogada = 1; igual = 1;
    tick();
    fez_jogada = 0;
    n_tests++; if (db_estado !== 4'h5 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL tie_registra: got %h timeout %b expected 5 0", db_estado, timeout); end
    tick();
    tick();
    n_tests++; if (db_estado !== 4'h8) begin n_fail++; $display("FAIL tie_prox_rodada: got %h expected 8", db_estado); end
  endtask
`else
  task automatic test_no_timeout();
    int lit; bit ok;
    do_reset();
    start_game();
    run_to_espera(lit, ok);
    repeat (100) tick();
    n_tests++; if (db_estado !== 4'h4 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL no_timeout: got %h timeout %b expected 4 0", db_estado, timeout); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_game();
    test_error();
    test_timing();
    test_ignore_mostra();
`ifdef TIMEOUT_EN
    test_timeout();
    test_tie();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
